// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core run/halt/step controller.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT,
        ST_STEP
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_DEBUG,
        CAUSE_BREAK,
        CAUSE_STEP
    } halt_cause_e;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    function automatic logic is_ebreak(input logic [31:0] instr);
        return instr == INST_EBREAK;
    endfunction

endpackage

// File: rtl/ctrl_counter.sv
// Enable-gated wrap-around counter with asynchronous active-low reset.
module ctrl_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step controller producing the per-cycle commit enable for
// the single-cycle RV32 datapath, with breakpoint/EBREAK halt and counters.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 32,
    parameter int BOOT_CYCLES  = 2,
    parameter bit START_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_out,
    input  logic [31:0]      inst,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [XLEN-1:0]  bp_addr,
    output logic             pc_en,
    output logic             rf_we_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    halt_cause_e halt_cause_q;
    halt_cause_e halt_cause_d;
    logic [3:0]  boot_cnt_q;
    logic [3:0]  boot_cnt_d;
    logic        skip_q;
    logic        skip_d;
    logic        commit;
    logic        brk;
    logic        cycle_en;

    // skip lets the instruction that caused a break execute once after resume
    always_comb begin
        brk          = (bp_en && (pc_out == bp_addr)) || is_ebreak(inst);
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        boot_cnt_d   = boot_cnt_q;
        skip_d       = skip_q;
        commit       = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                    if (START_HALTED) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_NONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (halt_req) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_DEBUG;
                end else if (brk && !skip_q) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_BREAK;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_HALT: begin
                if (step_req) begin
                    state_d = ST_STEP;
                end else if (resume_req) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end
            end
            ST_STEP: begin
                commit       = 1'b1;
                state_d      = ST_HALT;
                halt_cause_d = CAUSE_STEP;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            halt_cause_q <= CAUSE_NONE;
            boot_cnt_q   <= 4'd0;
            skip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            boot_cnt_q   <= boot_cnt_d;
            skip_q       <= skip_d;
        end
    end

    assign cycle_en   = (state_q != ST_BOOT);
    assign pc_en      = commit;
    assign rf_we_en   = commit;
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = halt_cause_q;

    ctrl_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cycle_en),
        .cnt (cycle_cnt)
    );

    ctrl_counter #(.W(CNT_W)) u_instret_cnt (
        .clk (clk),
        .rst (rst),
        .en  (commit),
        .cnt (instret_cnt)
    );

endmodule
